// File: rtl/wb_mdio_master_if.sv
// Wishbone bus bundle between the MAC configuration master and the MDIO controller.
// Signals:
//   wb_cyc, wb_stb, wb_we  cycle, strobe, write enable (master -> slave)
//   wb_adr[7:0]            byte address (master -> slave)
//   wb_dat_i[31:0]         write data (master -> slave)
//   wb_dat_o[31:0]         read data, valid with wb_ack (slave -> master)
//   wb_ack                 single-cycle acknowledge (slave -> master)
interface wb_mdio_master_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [7:0]  wb_adr;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
        input  wb_dat_o, wb_ack
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i,
        output wb_dat_o, wb_ack
    );
endinterface

// File: rtl/wb_mdio_master.sv
// Wishbone-attached MII management (MDIO) master. Generates MDC and runs
// clause-22 read/write frames to an external PHY.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   wb           Wishbone slave port (wb_mdio_master_if.slave)
//   mdc          MDIO clock, low while idle
//   mdio_o       serial data out, updated on falling MDC edges
//   mdio_oe      pad output enable (1 = drive)
//   mdio_i       serial data in (already synchronised), sampled on rising MDC edges
//   busy         frame in progress
// Register map: 0x14 CLKDIV, 0x18 ADDRESS {REGAD[12:8],PHYAD[4:0]}, 0x1C TXDATA,
//   0x20 COMMAND (bit1 read, bit2 write), 0x24 STATUS (bit1 busy), 0x28 RXDATA.
module wb_mdio_master #(
    parameter logic [7:0] DEFAULT_DIV  = 8'd24,
    parameter logic [5:0] PREAMBLE_LEN = 6'd32
) (
    input  logic                 clk,
    input  logic                 reset,
    wb_mdio_master_if.slave      wb,
    output logic                 mdc,
    output logic                 mdio_o,
    output logic                 mdio_oe,
    input  logic                 mdio_i,
    output logic                 busy
);

    typedef enum logic [2:0] {
        StIdle, StPreamble, StHeader, StTa, StData, StDone
    } state_e;

    // Bus side registers
    logic        ack_q, ack_d;
    logic [31:0] dat_o_q, dat_o_d;
    logic [7:0]  clkdiv_q, clkdiv_d;
    logic [4:0]  phyad_q, phyad_d;
    logic [4:0]  regad_q, regad_d;
    logic [15:0] txdata_q, txdata_d;
    logic [15:0] rxdata_q, rxdata_d;
    logic        start_q, start_d;
    logic        start_read_q, start_read_d;

    // Frame engine registers
    state_e      state_q, state_d;
    logic [5:0]  bit_q, bit_d;
    logic [6:0]  div_cnt_q, div_cnt_d;
    logic [6:0]  half_q, half_d;
    logic [31:0] sr_q, sr_d;
    logic [15:0] rx_sh_q, rx_sh_d;
    logic        is_read_q, is_read_d;
    logic        mdc_q, mdc_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;

    logic        req;
    logic        tick;
    logic        rise;
    logic        fall;
    logic        busy_next;
    logic [7:0]  div_eff;
    logic        unused_dat;

    assign unused_dat = ^wb.wb_dat_i[31:16];

    assign busy      = (state_q != StIdle) && (state_q != StDone);
    // STATUS/RXDATA reads see the values that take effect on this edge, so a read
    // coinciding with frame completion already reports the finished frame.
    assign busy_next = (state_d != StIdle) && (state_d != StDone);
    assign div_eff   = (clkdiv_q < 8'd2) ? 8'd2 : clkdiv_q;

    assign tick = (div_cnt_q == half_q - 7'd1);
    assign rise = tick & ~mdc_q;
    assign fall = tick & mdc_q;

    // Wishbone register access
    always_comb begin
        req          = wb.wb_cyc & wb.wb_stb & ~ack_q;
        ack_d        = req;
        dat_o_d      = 32'd0;
        clkdiv_d     = clkdiv_q;
        phyad_d      = phyad_q;
        regad_d      = regad_q;
        txdata_d     = txdata_q;
        start_d      = 1'b0;
        start_read_d = start_read_q;
        if (req && wb.wb_we) begin
            case (wb.wb_adr)
                8'h14: clkdiv_d = wb.wb_dat_i[7:0];
                8'h18: begin
                    phyad_d = wb.wb_dat_i[4:0];
                    regad_d = wb.wb_dat_i[12:8];
                end
                8'h1C: txdata_d = wb.wb_dat_i[15:0];
                8'h20: begin
                    if (!busy && !start_q && (wb.wb_dat_i[1] || wb.wb_dat_i[2])) begin
                        start_d      = 1'b1;
                        start_read_d = wb.wb_dat_i[1];
                    end
                end
                default: ;
            endcase
        end else if (req) begin
            case (wb.wb_adr)
                8'h14:   dat_o_d = {24'd0, clkdiv_q};
                8'h18:   dat_o_d = {19'd0, regad_q, 3'd0, phyad_q};
                8'h1C:   dat_o_d = {16'd0, txdata_q};
                8'h24:   dat_o_d = {30'd0, busy_next, 1'b0};
                8'h28:   dat_o_d = {16'd0, rxdata_d};
                default: dat_o_d = 32'd0;
            endcase
        end
    end

    // Frame FSM: next state and outputs
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        div_cnt_d = div_cnt_q;
        half_d    = half_q;
        sr_d      = sr_q;
        rx_sh_d   = rx_sh_q;
        is_read_d = is_read_q;
        mdc_d     = mdc_q;
        mdio_o_d  = mdio_o_q;
        mdio_oe_d = mdio_oe_q;
        rxdata_d  = rxdata_q;
        case (state_q)
            StIdle, StDone: begin
                state_d   = StIdle;
                mdc_d     = 1'b0;
                mdio_o_d  = 1'b1;
                mdio_oe_d = 1'b0;
                if (start_q) begin
                    state_d   = StPreamble;
                    bit_d     = 6'd0;
                    div_cnt_d = 7'd0;
                    half_d    = div_eff[7:1];
                    is_read_d = start_read_q;
                    // ST, OP, PHYAD, REGAD, TA, DATA; TA/DATA are don't-care on reads
                    sr_d      = {2'b01, start_read_q ? 2'b10 : 2'b01, phyad_q, regad_q,
                                 2'b10, start_read_q ? 16'hFFFF : txdata_q};
                    mdio_o_d  = 1'b1;
                    mdio_oe_d = 1'b1;
                end
            end
            default: begin
                div_cnt_d = tick ? 7'd0 : div_cnt_q + 7'd1;
                if (tick) mdc_d = ~mdc_q;
                if (rise && state_q == StData && is_read_q) begin
                    rx_sh_d = {rx_sh_q[14:0], mdio_i};
                end
                if (fall) begin
                    // Default on each falling edge: present next header/data bit
                    bit_d    = bit_q + 6'd1;
                    mdio_o_d = sr_q[31];
                    sr_d     = {sr_q[30:0], 1'b0};
                    case (state_q)
                        StPreamble: begin
                            if (bit_q == PREAMBLE_LEN - 6'd1) begin
                                state_d = StHeader;
                                bit_d   = 6'd0;
                            end else begin
                                mdio_o_d = 1'b1;
                                sr_d     = sr_q;
                            end
                        end
                        StHeader: begin
                            if (bit_q == 6'd13) begin
                                state_d = StTa;
                                bit_d   = 6'd0;
                                if (is_read_q) mdio_oe_d = 1'b0;
                            end
                        end
                        StTa: begin
                            if (bit_q == 6'd1) begin
                                state_d = StData;
                                bit_d   = 6'd0;
                            end
                        end
                        StData: begin
                            if (bit_q == 6'd15) begin
                                state_d   = StDone;
                                mdio_o_d  = 1'b1;
                                mdio_oe_d = 1'b0;
                                sr_d      = sr_q;
                                if (is_read_q) rxdata_d = rx_sh_q;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q        <= 1'b0;
            dat_o_q      <= 32'd0;
            clkdiv_q     <= DEFAULT_DIV;
            phyad_q      <= 5'd0;
            regad_q      <= 5'd0;
            txdata_q     <= 16'd0;
            rxdata_q     <= 16'd0;
            start_q      <= 1'b0;
            start_read_q <= 1'b0;
            state_q      <= StIdle;
            bit_q        <= 6'd0;
            div_cnt_q    <= 7'd0;
            half_q       <= 7'd1;
            sr_q         <= 32'd0;
            rx_sh_q      <= 16'd0;
            is_read_q    <= 1'b0;
            mdc_q        <= 1'b0;
            mdio_o_q     <= 1'b1;
            mdio_oe_q    <= 1'b0;
        end else begin
            ack_q        <= ack_d;
            dat_o_q      <= dat_o_d;
            clkdiv_q     <= clkdiv_d;
            phyad_q      <= phyad_d;
            regad_q      <= regad_d;
            txdata_q     <= txdata_d;
            rxdata_q     <= rxdata_d;
            start_q      <= start_d;
            start_read_q <= start_read_d;
            state_q      <= state_d;
            bit_q        <= bit_d;
            div_cnt_q    <= div_cnt_d;
            half_q       <= half_d;
            sr_q         <= sr_d;
            rx_sh_q      <= rx_sh_d;
            is_read_q    <= is_read_d;
            mdc_q        <= mdc_d;
            mdio_o_q     <= mdio_o_d;
            mdio_oe_q    <= mdio_oe_d;
        end
    end

    assign wb.wb_ack   = ack_q;
    assign wb.wb_dat_o = dat_o_q;
    assign mdc         = mdc_q;
    assign mdio_o      = mdio_o_q;
    assign mdio_oe     = mdio_oe_q;

endmodule
